// File: rtl/unsigned_div_pkg.sv
// Shared types and constants for the unsigned 16-by-8 sequential divider.
// Holds the FSM state encoding, default operand widths, iteration counts
// for exact and truncated modes, and the divide-by-zero quotient pattern.
package unsigned_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DW = 16;
  localparam int DEF_VW = 8;

  // One quotient bit per iteration; truncated mode skips the two dividend LSBs
  localparam int ITER_EXACT = 16;
  localparam int ITER_TRUNC = 14;

  localparam logic [DEF_DW-1:0] DBZ_QUOT = 16'hFFFF;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and report the quotient bit.
// Purely combinational, zero latency, no handshake.
module div_restoring_step #(
  parameter int VW = 8
) (
  input  logic [VW-1:0] rem_in,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] rem_out,
  output logic          qbit
);

  logic [VW:0] rem9;
  logic [VW:0] diff;

  // Trial subtraction on the widened remainder; restore when it would go negative
  always_comb begin
    rem9    = {rem_in, bit_in};
    diff    = rem9 - {1'b0, divisor};
    qbit    = 1'b0;
    rem_out = rem9[VW-1:0];
    if (rem9 >= {1'b0, divisor}) begin
      qbit    = 1'b1;
      // rem_in < divisor, so the difference is always below the divisor and fits VW bits
      rem_out = diff[VW-1:0];
    end
  end

endmodule

// File: rtl/unsigned_16by8_seq_div.sv
// Sequential unsigned 16/8 restoring divider, one quotient bit per cycle.
// Latency: 16 cycles accept-to-result (14 with UNSIGNED_DIV_TRUNC_LSB_EN), 1 cycle for divide-by-zero.
// Backpressure: result held in DONE until out_ready; in_ready low until the result is taken.
module unsigned_16by8_seq_div
  import unsigned_div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] z,
  input  logic [VW-1:0] y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          dbz
);

  localparam int CW = $clog2(DW + 1);

`ifdef UNSIGNED_DIV_TRUNC_LSB_EN
  localparam int ITERS = ITER_TRUNC;
`else
  localparam int ITERS = ITER_EXACT;
`endif

  state_t        state;
  logic [DW-1:0] dvd;
  logic [VW-1:0] dvs;
  logic [CW-1:0] cnt;
  logic [VW-1:0] step_rem;
  logic          step_q;

  // r doubles as the partial remainder while BUSY; it is only qualified once out_valid rises
  div_restoring_step #(.VW(VW)) u_step (
    .rem_in  (r),
    .bit_in  (dvd[DW-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .qbit    (step_q)
  );

  // Control FSM with registered handshake outputs and the datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      q         <= '0;
      r         <= '0;
      dbz       <= 1'b0;
      dvd       <= '0;
      dvs       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd      <= z;
            dvs      <= y;
            q        <= '0;
            r        <= '0;
            dbz      <= 1'b0;
            cnt      <= CW'(ITERS);
            in_ready <= 1'b0;
            if (y == '0) begin
              q     <= DW'(DBZ_QUOT);
              r     <= z[VW-1:0];
              dbz   <= 1'b1;
              state <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          dvd <= dvd << 1;
          q   <= {q[DW-2:0], step_q};
          r   <= step_rem;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
`ifdef UNSIGNED_DIV_TRUNC_LSB_EN
            // Only the upper dividend bits were divided; restore the quotient's weight
            q <= {q[DW-4:0], step_q, 2'b00};
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Divide-by-zero enters here with out_valid low and raises it one cycle later
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_16by8_seq_div.sv
// Directed-vector bench for unsigned_16by8_seq_div.
// Latency, result values, backpressure hold and mid-operation reset.
// Exact-mode vectors by default; truncated-mode vectors with UNSIGNED_DIV_TRUNC_LSB_EN.
module tb_unsigned_16by8_seq_div;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] z;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic [7:0]  r;
  logic        dbz;

  int n_tests = 0;
  int n_fail  = 0;

  unsigned_16by8_seq_div dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Accept one operation, measure latency, optionally stall the result, then drain it
  task automatic run_op(input string tag, input logic [15:0] zz, input logic [7:0] yy,
                        input logic [15:0] eq, input logic [7:0] er, input logic edbz,
                        input int elat, input int hold);
    int lat;
    logic [15:0] q0;
    logic [7:0]  r0;
    logic        d0;
    chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    z = zz;
    y = yy;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    z = 16'hDEAD;
    y = 8'h5A;
    chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(elat));
    chk({tag, ".q"},   32'(q),   32'(eq));
    chk({tag, ".r"},   32'(r),   32'(er));
    chk({tag, ".dbz"}, 32'(dbz), 32'(edbz));
    chk({tag, ".excl"}, 32'(in_ready), 32'd0);
    if (hold > 0) begin
      q0 = q;
      r0 = r;
      d0 = dbz;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".hold_rdy"},   32'(in_ready),  32'd0);
        chk({tag, ".hold_q"},     32'(q),         32'(q0));
        chk({tag, ".hold_r"},     32'(r),         32'(r0));
        chk({tag, ".hold_dbz"},   32'(dbz),       32'(d0));
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, ".drain_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".drain_rdy"},   32'(in_ready),  32'd1);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    z         = '0;
    y         = '0;
    #1;
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.q",         32'(q),         32'd0);
    chk("rst.r",         32'(r),         32'd0);
    chk("rst.dbz",       32'(dbz),       32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef UNSIGNED_DIV_TRUNC_LSB_EN
    // (1003>>2)=250; 250/7 = 35 r 5; quotient weighted back by 4
    run_op("trunc",   16'd1003,  8'd7, 16'd140,   8'd5,    1'b0, 14, 0);
    run_op("trunc_bp",16'd255,   8'd16,16'd12,    8'd15,   1'b0, 14, 5);
    run_op("dbz",     16'h1234,  8'd0, 16'hFFFF,  8'h34,   1'b1, 1,  0);
`else
    run_op("basic",   16'd1000,  8'd7, 16'd142,   8'd6,    1'b0, 16, 0);
    run_op("maxq",    16'd65535, 8'd1, 16'd65535, 8'd0,    1'b0, 16, 0);
    run_op("dbz",     16'h1234,  8'd0, 16'hFFFF,  8'h34,   1'b1, 1,  0);
    run_op("bp_dbz",  16'h00AB,  8'd0, 16'hFFFF,  8'hAB,   1'b1, 1,  5);
    run_op("bp",      16'd1000,  8'd7, 16'd142,   8'd6,    1'b0, 16, 5);
    run_op("after_bp",16'd255,   8'd16,16'd15,    8'd15,   1'b0, 16, 0);
    run_op("div_big", 16'd65535, 8'd255,16'd257,  8'd0,    1'b0, 16, 0);
    run_op("z_lt_y",  16'd5,     8'd200,16'd0,    8'd5,    1'b0, 16, 0);

    // Abort 50000/3 after the eighth iteration
    z = 16'd50000;
    y = 8'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort.busy_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    chk("abort.in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("abort.no_stale", 32'(seen), 32'd0);
    run_op("post_abort", 16'd50000, 8'd3, 16'd16666, 8'd2, 1'b0, 16, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/unsigned_16by8_seq_div.md
# unsigned_16by8_seq_div

Sequential unsigned divider, the inverse operation to the unsigned 8x8 multipliers: it takes a 16-bit product-width dividend and an 8-bit divisor and returns a 16-bit quotient and 8-bit remainder. It uses a restoring algorithm, one quotient bit per cycle, with valid/ready handshakes on both sides. It sits downstream of the multiplier array for error-analysis and round-trip benches. An optional approximate mode truncates the two dividend LSBs, matching the truncation style of the multiplier family.

## Interface
- DW, 16, dividend/quotient width
- VW, 8, divisor/remainder width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  divider idle and able to accept
- z  in  DW  dividend
- y  in  VW  divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- q  out  DW  quotient
- r  out  VW  remainder
- dbz  out  1  divide-by-zero flag, qualified by out_valid

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch z and y;
  - clear quotient and partial remainder;
  - load iteration counter;
  - go to BUSY, or to DONE if y==0.
- y==0: q=16'hFFFF, r=z[7:0], dbz=1.
- BUSY, per cycle:
  - rem9 = {rem8, next dividend bit, MSB first};
  - if rem9 >= {1'b0,y}, then rem8 = rem9 - y and qbit = 1;
  - else rem8 = rem9[7:0] and qbit = 0;
  - shift qbit into q.
  - Partial remainder is 9 bits internally. The stored remainder always fits 8 bits.
- Iterations: DW (16). After the last iteration go to DONE.
- DONE: out_valid=1. q, r and dbz are held stable while out_ready=0. On out_valid&&out_ready, go to IDLE.
- in_ready=0 in BUSY and DONE. in_valid and operand changes are ignored there.
- No pipelining: one operation in flight.
- Reset values: in_ready=1, out_valid=0, q=0, r=0, dbz=0, state=IDLE.
- Handshakes are ignored while rst is high.
- rst asserted mid-BUSY or in DONE aborts the operation. No result is ever presented for it.

## Timing
- Accept edge E0. Iterations occur on E1..E16. out_valid rises after E16, i.e. 16 cycles after acceptance.
- Divide-by-zero: out_valid rises after E1.
- Output handshake at edge Ek: out_valid and in_ready=1 take effect after Ek.
- Minimum spacing between accepts is 18 cycles with out_ready tied high.
- in_ready and out_valid are never high together.

## Configuration
- UNSIGNED_DIV_TRUNC_LSB_EN defined:
  - dividend bits [1:0] are discarded and only 14 iterations run;
  - q = ((z>>2)/y)<<2, with q[1:0]=0;
  - r = (z>>2)%y;
  - latency is 14 cycles.
  - Divide-by-zero handling is unchanged.
- Undefined: exact division, 16 iterations.

## Structure
- Package unsigned_div_pkg holds:
  - the state enum (IDLE/BUSY/DONE);
  - DW/VW default constants;
  - iteration counts for exact and truncated modes;
  - the divide-by-zero quotient constant 16'hFFFF.
- Sub-module div_restoring_step is purely combinational. It takes rem8, the dividend bit and the divisor, and returns the new rem8 and qbit. It is instantiated once in the top.

## Test plan
- Basic division: z=1000, y=7 -> q=142, r=6, dbz=0; out_valid exactly 16 cycles after accept.
- Maximum quotient: z=65535, y=1 -> q=65535, r=0.
- Divide by zero: z=16'h1234, y=0 -> q=16'hFFFF, r=8'h34, dbz=1; out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required response: q, r and dbz stable, and in_ready=0 throughout. After the handshake, in_ready=1 the next cycle, and a second op z=255, y=16 returns q=15, r=15.
- Mid-operation reset: assert rst after iteration 8 of z=50000, y=3. Required response: out_valid=0 and in_ready=1 immediately, with no stale result. A new op z=50000, y=3 then returns q=16666, r=2.
- Truncated mode (macro defined): z=1003, y=7 -> q=140, r=5; out_valid 14 cycles after accept.
